pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter RESET_HOLD, default 2, cycles xreset stays high after rst_n release (range 1..15).
REQ-002 SHALL provide parameter FLUSH_CYCLES, default 2, cycles flush stays high after a taken jump (range 1..7).
REQ-003 SHALL provide parameter TIMEOUT, default 255, maximum MEM cycles before the bus-error abort (range 1..255).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- ivalid  in  1  current insn from the instruction bus is valid.
- lcc, scc, jal, jalr, bcc  in  1 each  decoder class bits.
- bcc_taken  in  1  branch condition true.
- dack  in  1  data-bus acknowledge.
- halt_req  in  1  debug halt request, level.
- xreset  out  1  decoder/pipeline local reset.
- flush  out  1  decoder flush.
- hold  out  1  freeze PC and fetch.
- drd  out  1  data read strobe.
- dwr  out  1  data write strobe.
- halted  out  1  core halted.
- bus_err  out  1  one-cycle timeout pulse.
- state  out  3  current state, for debug.

Function
REQ-006 SHALL implement the states RST, RUN, MEM, FLUSH and HALT; state encoding SHALL come from the package.
REQ-007 SHALL define jump = ivalid & (jal | jalr | (bcc & bcc_taken)) and mem = ivalid & (lcc | scc), both evaluated only in RUN.
REQ-008 In RST: xreset=1, hold=1; RST SHALL move to RUN after exactly RESET_HOLD rising edges following rst_n release.
REQ-009 In RUN, priority SHALL be jump > mem > halt_req.
REQ-010 On a RUN jump: flush=0 in the detect cycle; the next state SHALL be FLUSH with flush=1 for exactly FLUSH_CYCLES cycles, then RUN.
REQ-011 On a RUN mem: drd=lcc / dwr=scc, combinational in the same cycle; if dack=1 in that cycle, stay in RUN with hold=0 (zero-wait access); otherwise hold=1 and go to MEM, latching the access type.
REQ-012 In MEM: the latched drd/dwr and hold=1 SHALL be held until the dack cycle (inclusive); on dack, return to RUN next cycle; halt_req and jumps are ignored in MEM.
REQ-013 The MEM timeout counter SHALL clear on MEM entry and increment each MEM cycle without dack.
REQ-014 When the counter reaches TIMEOUT without dack: bus_err=1 for that single cycle, drd/dwr drop next cycle, state goes to RUN; dack in that same cycle SHALL win, with no bus_err.
REQ-015 RUN with halt_req, and no jump or mem: go to HALT; HALT SHALL drive hold=1, halted=1 and leave to RUN in the cycle after halt_req=0.
REQ-016 In FLUSH: hold=0, and lcc/scc/jump SHALL be ignored.
REQ-017 Defaults: xreset=1 only in RST; flush=1 only in FLUSH; halted=1 only in HALT.
REQ-018 drd and dwr SHALL never be 1 together; if lcc and scc are both 1, treat the access as a load.
REQ-019 All counters SHALL saturate and never wrap.

Reset
REQ-020 rst_n=0 SHALL force, asynchronously: state=RST, all counters=0, xreset=1, hold=1, flush=0, drd=0, dwr=0, halted=0, bus_err=0.
REQ-021 rst_n assertion mid-MEM or mid-FLUSH SHALL abort immediately, with no bus_err.

Structure
REQ-022 Package pipe_ctrl_pkg SHALL hold the state typedef (3-bit) and the default values of RESET_HOLD, FLUSH_CYCLES and TIMEOUT.
REQ-023 One sub-module, cyc_counter (load/enable/saturating up-counter, 8-bit, terminal-count output), SHALL be instantiated for the RST, FLUSH and MEM timing.

Verification
REQ-024 Release rst_n at cycle 0 -> xreset=1 for cycles 0-1, state=RUN and xreset=0 at cycle 2.
REQ-025 RUN, ivalid=1, jal=1 -> flush=0 that cycle, flush=1 for next 2 cycles, then RUN; bcc=1 with bcc_taken=0 -> no flush.
REQ-026 lcc=1 with dack on the 4th cycle -> drd=1 and hold=1 for 4 cycles, hold=0 on the 5th; lcc with same-cycle dack -> single drd cycle, hold=0.
REQ-027 scc=1, dack never -> dwr held, bus_err=1 exactly once at TIMEOUT, then RUN; repeat with dack in the timeout cycle -> no bus_err.
REQ-028 halt_req=1 together with jal=1 -> FLUSH first, HALT after flush ends; halt_req=0 -> RUN next cycle.
REQ-029 rst_n=0 during MEM -> drd=0, xreset=1 immediately, state=RST, bus_err never asserted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter defaults for the pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_RUN   = 3'd1,
        ST_MEM   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam int CNT_W            = 8;
    localparam int RESET_HOLD_DEF   = 2;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/pipe_ctrl_cyc_counter.sv
// Load/enable saturating up-counter with a terminal-count compare.
module cyc_counter
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Load clears the count; it wins over enable and the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt >= term);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: reset stretch, jump flush, data-bus wait with timeout, debug halt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RESET_HOLD   = RESET_HOLD_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ivalid,
    input  logic       lcc,
    input  logic       scc,
    input  logic       jal,
    input  logic       jalr,
    input  logic       bcc,
    input  logic       bcc_taken,
    input  logic       dack,
    input  logic       halt_req,
    output logic       xreset,
    output logic       flush,
    output logic       hold,
    output logic       drd,
    output logic       dwr,
    output logic       halted,
    output logic       bus_err,
    output logic [2:0] state
);

    state_t           st;
    logic             rd_q;
    logic             wr_q;
    logic             run;
    logic             jump;
    logic             mem;
    logic             mem_wait;
    logic             tc;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] term;

    assign run      = (st == ST_RUN);
    assign jump     = run & ivalid & (jal | jalr | (bcc & bcc_taken));
    assign mem      = run & ivalid & (lcc | scc) & ~jump;
    assign mem_wait = mem & ~dack;

    // Terminal count is N-1 because the counter starts at 0 in the first cycle
    // of each timed state; a MEM access therefore lasts at most TIMEOUT cycles.
    always_comb begin
        term = '0;
        case (st)
            ST_RST:   term = CNT_W'(RESET_HOLD - 1);
            ST_FLUSH: term = CNT_W'(FLUSH_CYCLES - 1);
            ST_MEM:   term = CNT_W'(TIMEOUT - 1);
            default:  term = '0;
        endcase
    end

    assign cnt_load = jump | mem_wait;
    assign cnt_en   = (st == ST_RST) | (st == ST_FLUSH) | ((st == ST_MEM) & ~dack);

    cyc_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .term  (term),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= ST_RST;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            case (st)
                ST_RST:   if (tc) st <= ST_RUN;
                ST_RUN: begin
                    if (jump) begin
                        st <= ST_FLUSH;
                    end else if (mem_wait) begin
                        st   <= ST_MEM;
                        rd_q <= lcc;
                        wr_q <= scc & ~lcc;
                    end else if (!mem && halt_req) begin
                        st <= ST_HALT;
                    end
                end
                ST_MEM:   if (dack || tc) st <= ST_RUN;
                ST_FLUSH: if (tc) st <= ST_RUN;
                ST_HALT:  if (!halt_req) st <= ST_RUN;
                default:  st <= ST_RST;
            endcase
        end
    end

    // A load takes precedence when both class bits are set, so strobes stay exclusive.
    assign xreset  = (st == ST_RST);
    assign flush   = (st == ST_FLUSH);
    assign halted  = (st == ST_HALT);
    assign hold    = (st == ST_RST) | (st == ST_MEM) | (st == ST_HALT) | mem_wait;
    assign drd     = (mem & lcc) | ((st == ST_MEM) & rd_q);
    assign dwr     = (mem & scc & ~lcc) | ((st == ST_MEM) & wr_q);
    assign bus_err = (st == ST_MEM) & ~dack & tc;
    assign state   = st;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with default parameters.
module tb_pipe_ctrl;

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam int         TO      = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ivalid, lcc, scc, jal, jalr, bcc, bcc_taken, dack, halt_req;
    logic       xreset, flush, hold, drd, dwr, halted, bus_err;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;
    int pulses;
    int strobe_lost;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ivalid    (ivalid),
        .lcc       (lcc),
        .scc       (scc),
        .jal       (jal),
        .jalr      (jalr),
        .bcc       (bcc),
        .bcc_taken (bcc_taken),
        .dack      (dack),
        .halt_req  (halt_req),
        .xreset    (xreset),
        .flush     (flush),
        .hold      (hold),
        .drd       (drd),
        .dwr       (dwr),
        .halted    (halted),
        .bus_err   (bus_err),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(negedge clk);
    endtask

    task automatic clear_in();
        ivalid = 0; lcc = 0; scc = 0; jal = 0; jalr = 0;
        bcc = 0; bcc_taken = 0; dack = 0;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 0; halt_req = 0;
        clear_in();
        #3;
        chk("rst_state", state, S_RST);
        chk("rst_xreset", xreset, 1);
        chk("rst_hold", hold, 1);
        chk("rst_quiet", {flush, drd, dwr, halted, bus_err}, 0);
        repeat (2) go();

        // Reset release: cycles 0 and 1 in RST, RUN at cycle 2.
        rst_n = 1; #1;
        chk("rel_c0_xreset", xreset, 1);
        go(); #1;
        chk("rel_c1_state", state, S_RST);
        go(); #1;
        chk("rel_c2_state", state, S_RUN);
        chk("rel_c2_xreset", xreset, 0);
        chk("rel_c2_hold", hold, 0);

        // Taken jal: no flush in the detect cycle, then two flush cycles.
        go(); ivalid = 1; jal = 1; #1;
        chk("jal_detect_flush", flush, 0);
        go(); clear_in(); #1;
        chk("jal_f1_state", state, S_FLUSH);
        chk("jal_f1_flush_hold", {flush, hold}, 2'b10);
        go(); ivalid = 1; lcc = 1; #1;
        chk("jal_f2_flush", flush, 1);
        chk("flush_ignores_lcc", {drd, hold}, 2'b00);
        go(); clear_in(); #1;
        chk("jal_back_run", state, S_RUN);
        chk("jal_back_flush", flush, 0);

        // Branch not taken, then taken.
        go(); ivalid = 1; bcc = 1; #1;
        chk("bcc_nt_flush", flush, 0);
        go(); #1;
        chk("bcc_nt_state", state, S_RUN);
        bcc_taken = 1; #1;
        go(); clear_in(); #1;
        chk("bcc_t_state", state, S_FLUSH);
        go(); go(); #1;
        chk("bcc_t_back_run", state, S_RUN);

        // Load acknowledged on the 4th cycle.
        go(); ivalid = 1; lcc = 1; #1;
        chk("ld_c1", {drd, dwr, hold}, 3'b101);
        go(); clear_in(); #1;
        chk("ld_c2_state", state, S_MEM);
        chk("ld_c2", {drd, dwr, hold}, 3'b101);
        go(); #1;
        chk("ld_c3", {drd, hold}, 2'b11);
        go(); dack = 1; #1;
        chk("ld_c4", {drd, hold, bus_err}, 3'b110);
        go(); clear_in(); #1;
        chk("ld_c5_state", state, S_RUN);
        chk("ld_c5", {drd, hold}, 2'b00);

        // Zero-wait load, then lcc+scc together treated as a load.
        go(); ivalid = 1; lcc = 1; dack = 1; #1;
        chk("zw_ld", {drd, dwr, hold}, 3'b100);
        scc = 1; #1;
        chk("ld_st_both", {drd, dwr}, 2'b10);
        go(); clear_in(); #1;
        chk("zw_after", {state, drd}, {S_RUN, 1'b0});

        // Store with no acknowledge: bus_err once in the TO-th MEM cycle.
        go(); ivalid = 1; scc = 1; #1;
        chk("st_to_c1", {drd, dwr, hold}, 3'b011);
        pulses = 0; strobe_lost = 0;
        for (int i = 1; i <= TO; i++) begin
            go(); clear_in(); #1;
            if (bus_err) pulses++;
            if (!dwr || !hold || state != S_MEM) strobe_lost++;
            if (i == TO) chk("st_to_buserr", bus_err, 1);
        end
        chk("st_to_pulses", pulses, 1);
        chk("st_to_held", strobe_lost, 0);
        go(); #1;
        chk("st_to_after", {state, dwr, bus_err}, {S_RUN, 2'b00});

        // Same, but dack arrives in the timeout cycle.
        go(); ivalid = 1; scc = 1; #1;
        pulses = 0;
        for (int i = 1; i <= TO; i++) begin
            go(); clear_in();
            if (i == TO) dack = 1;
            #1;
            if (bus_err) pulses++;
        end
        chk("st_ack_pulses", pulses, 0);
        chk("st_ack_dwr", dwr, 1);
        go(); clear_in(); #1;
        chk("st_ack_after", {state, dwr}, {S_RUN, 1'b0});

        // Halt requested alongside a jump: flush first, then halt.
        go(); ivalid = 1; jal = 1; halt_req = 1; #1;
        chk("hj_detect", {state, flush}, {S_RUN, 1'b0});
        go(); clear_in(); #1;
        chk("hj_f1", state, S_FLUSH);
        go(); #1;
        chk("hj_f2", state, S_FLUSH);
        go(); #1;
        chk("hj_run", state, S_RUN);
        go(); #1;
        chk("hj_halt", {state, halted, hold}, {S_HALT, 2'b11});
        go(); halt_req = 0; #1;
        chk("hj_release_cycle", state, S_HALT);
        go(); #1;
        chk("hj_back_run", {state, halted}, {S_RUN, 1'b0});

        // Reset asserted mid-MEM aborts immediately.
        go(); ivalid = 1; lcc = 1; #1;
        go(); clear_in(); #1;
        chk("rm_in_mem", state, S_MEM);
        #2 rst_n = 0; #1;
        chk("rm_state", state, S_RST);
        chk("rm_out", {xreset, hold, drd, dwr, bus_err}, 5'b11000);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            go(); #1;
            if (bus_err) pulses++;
        end
        chk("rm_no_buserr", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
